// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV64M/RV32M multiply/divide unit with valid/ready handshake and tag passthrough.
// Optional MDU_EARLY_OUT_EN: divide-by-zero, signed overflow and multiply-by-zero finish at accept.
module mdu_iter #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CW = $clog2(XLEN + 1);
    localparam int SH = XLEN - 32;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] q, d, r;
    logic            k_mul, k_rem, k_w, neg_q, neg_r;

    function automatic logic [XLEN-1:0] sx(input logic [XLEN-1:0] v);
        logic signed [XLEN-1:0] t;
        t = v << SH;
        return t >>> SH;
    endfunction

    function automatic logic [XLEN-1:0] zx(input logic [XLEN-1:0] v);
        return (v << SH) >> SH;
    endfunction

    logic            op_mul, op_div, op_rem, op_sgn, op_w, op_zx, op_ok, na, nb, div0;
    logic [XLEN-1:0] ea, eb, ma, mb;

    always_comb begin
        op_mul = in_op == 4'd1 || in_op == 4'd6;
        op_div = in_op == 4'd2 || in_op == 4'd3 || in_op == 4'd7 || in_op == 4'd8;
        op_rem = in_op == 4'd4 || in_op == 4'd5 || in_op == 4'd9 || in_op == 4'd10;
        op_sgn = in_op == 4'd2 || in_op == 4'd4 || in_op == 4'd7 || in_op == 4'd9;
        op_w   = in_op >= 4'd6 && in_op <= 4'd10;
        op_zx  = in_op == 4'd8 || in_op == 4'd10;
        op_ok  = op_mul || op_div || op_rem;
        ea     = op_w ? (op_zx ? zx(in_a) : sx(in_a)) : in_a;
        eb     = op_w ? (op_zx ? zx(in_b) : sx(in_b)) : in_b;
        na     = op_sgn && ea[XLEN-1];
        nb     = op_sgn && eb[XLEN-1];
        ma     = na ? -ea : ea;
        mb     = nb ? -eb : eb;
        div0   = eb == '0;
    end

`ifdef MDU_EARLY_OUT_EN
    logic            ovf, early;
    logic [XLEN-1:0] early_res;
    assign ovf       = op_sgn && eb == '1 &&
                       ea == (op_w ? sx(XLEN'(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}});
    assign early     = op_mul ? (ea == '0 || eb == '0) : (op_div || op_rem) && (div0 || ovf);
    assign early_res = op_mul ? '0 : div0 ? (op_rem ? ea : '1) : (op_rem ? '0 : ea);
`else
    logic            early;
    logic [XLEN-1:0] early_res;
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    logic [XLEN:0]   rs, rt;
    logic            ge;
    logic [XLEN-1:0] q_n, d_n, r_n, raw, res;

    always_comb begin
        rs  = {r, q[XLEN-1]};
        rt  = rs - {1'b0, d};
        ge  = !rt[XLEN];
        q_n = k_mul ? q >> 1 : {q[XLEN-2:0], ge};
        d_n = k_mul ? d << 1 : d;
        r_n = k_mul ? r + (q[0] ? d : '0) : (ge ? rt[XLEN-1:0] : rs[XLEN-1:0]);
        raw = k_mul ? r_n : k_rem ? (neg_r ? -r_n : r_n) : (neg_q ? -q_n : q_n);
        res = k_w ? sx(raw) : raw;
    end

    assign in_ready = state == IDLE;
    assign busy     = state != IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            cnt        <= '0;
            q          <= '0;
            d          <= '0;
            r          <= '0;
            k_mul      <= 1'b0;
            k_rem      <= 1'b0;
            k_w        <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    out_tag <= in_tag;
                    k_mul   <= op_mul;
                    k_rem   <= op_rem;
                    k_w     <= op_w;
                    neg_q   <= (na ^ nb) && !div0;
                    neg_r   <= na;
                    // W dividends are left-aligned so 32 iterations consume all their bits
                    q       <= op_mul ? eb : ma << (op_w ? SH : 0);
                    d       <= op_mul ? ea : mb;
                    r       <= '0;
                    cnt     <= op_w ? CW'(32) : CW'(XLEN);
                    if (!op_ok || early) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= op_ok ? (op_w ? sx(early_res) : early_res) : '0;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    q   <= q_n;
                    d   <= d_n;
                    r   <= r_n;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= res;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed vectors for mdu_iter at XLEN=64, latencies follow MDU_EARLY_OUT_EN.
module tb_mdu_iter;
`ifdef MDU_EARLY_OUT_EN
    localparam int EL = 1;
    localparam int EW = 1;
`else
    localparam int EL = 65;
    localparam int EW = 33;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [3:0]  in_op;
    logic [63:0] in_a, in_b, out_result;
    logic [4:0]  in_tag, out_tag;
    int          vectors = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mdu_iter #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag);
        in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = 4'd3; in_a = '1; in_b = '1; in_tag = '1;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run(input string name, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag, input int lat,
                       input logic [63:0] exp);
        int cyc;
        check({name, "_ready"}, 64'(in_ready), 64'd1);
        issue(op, a, b, tag);
        wait_valid(cyc);
        check({name, "_lat"}, 64'(cyc), 64'(lat));
        check({name, "_res"}, out_result, exp);
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int cyc;
        logic seen;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_result", out_result, 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        run("mul_neg1x3", 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd5, 65, 64'hFFFF_FFFF_FFFF_FFFD);
        run("div_m7_2", 4'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 65, 64'hFFFF_FFFF_FFFF_FFFD);
        run("rem_m7_2", 4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 65, 64'hFFFF_FFFF_FFFF_FFFF);
        run("remu_7_0", 4'd5, 64'd7, 64'd0, 5'd8, EL, 64'd7);
        run("divu_7_0", 4'd3, 64'd7, 64'd0, 5'd9, EL, 64'hFFFF_FFFF_FFFF_FFFF);
        run("divw_ovf", 4'd7, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd10, EW,
            64'hFFFF_FFFF_8000_0000);
        run("divuw_fffe", 4'd8, 64'h0000_0000_FFFF_FFFE, 64'd1, 5'd11, 33, 64'hFFFF_FFFF_FFFF_FFFE);
        run("mul_0x5", 4'd1, 64'd0, 64'd5, 5'd12, EL, 64'd0);
        run("div_min_m1", 4'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, EL,
            64'h8000_0000_0000_0000);
        run("remw_m7_2", 4'd9, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd14, 33, 64'hFFFF_FFFF_FFFF_FFFF);
        run("mulw_sext", 4'd6, 64'h1234_5678_4000_0000, 64'd2, 5'd15, 33, 64'hFFFF_FFFF_8000_0000);
        run("remuw_div0", 4'd10, 64'hFFFF_FFFF_0000_0010, 64'hABCD_0000_0000_0000, 5'd16, EW, 64'h10);
        run("nop", 4'd0, 64'd5, 64'd6, 5'd17, 1, 64'd0);
        run("op12", 4'd12, 64'd5, 64'd6, 5'd18, 1, 64'd0);
        run("div_100_m7", 4'd2, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd19, 65, 64'hFFFF_FFFF_FFFF_FFF2);
        run("rem_100_m7", 4'd4, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd20, 65, 64'd2);

        issue(4'd1, 64'd6, 64'd7, 5'd21);
        wait_valid(cyc);
        check("bp_lat", 64'(cyc), 64'd65);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_res", out_result, 64'd42);
            check("bp_tag", 64'(out_tag), 64'd21);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_idle", 64'(busy), 64'd0);
        run("after_bp", 4'd3, 64'd100, 64'd7, 5'd22, 65, 64'd14);

        issue(4'd2, 64'd100, 64'd7, 5'd3);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fl_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("fl_quiet", 64'(seen), 64'd0);
        run("mulw_after_flush", 4'd6, 64'd6, 64'd7, 5'd9, 33, 64'd42);

        in_op = 4'd1; in_a = 64'd3; in_b = 64'd3; in_tag = 5'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_beats_valid", 64'(busy), 64'd0);

        issue(4'd1, 64'd3, 64'd3, 5'd2);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midop_rst_busy", 64'(busy), 64'd0);
        check("midop_rst_valid", 64'(out_valid), 64'd0);
        run("after_rst", 4'd1, 64'd9, 64'd9, 5'd4, 65, 64'd81);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the execute stage; implements the RV64M/RV32M op set (MUL, DIV, DIVU, REM, REMU and the W variants).
- Replaces single-cycle combinational MDU usage with a valid/ready handshake, so the pipeline stalls only while the unit is busy.
- Radix-2 shift-add multiplier and restoring divider share one iteration counter.
- A destination tag travels with each op so writeback can match the result to its instruction.

Parameters:
- XLEN, 64, operand/result width; legal values 32 or 64.
- TAG_W, 5, width of the opaque tag carried with each op (destination register address).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  op request
- in_ready  out  1  unit can accept an op
- in_op  in  4  op code: 0 NOP, 1 MUL, 2 DIV, 3 DIVU, 4 REM, 5 REMU, 6 MULW, 7 DIVW, 8 DIVUW, 9 REMW, 10 REMUW
- in_a  in  XLEN  rs1 value
- in_b  in  XLEN  rs2 value
- in_tag  in  TAG_W  tag
- flush  in  1  kill any in-flight op
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_result  out  XLEN  result
- out_tag  out  TAG_W  tag of result
- busy  out  1  state != IDLE

Behaviour:
- Reset:
  - state IDLE; in_ready=1; out_valid=0; out_result=0; out_tag=0; busy=0.
  - Reset mid-operation discards the op.
- States:
  - IDLE: accept when in_valid && in_ready; latch op, operands and tag.
    - Iterating ops go to CALC with cnt=N, where N=XLEN for 64-bit ops and N=32 for W ops.
    - NOP and codes 11-15 go directly to DONE with result 0.
  - CALC: one iteration per cycle; cnt decrements; the cycle with cnt==1 moves to DONE.
  - DONE: out_valid=1; result and tag held stable until out_ready; then IDLE.
- Latency:
  - in_ready=1 only in IDLE, so there is no accept in the DONE→IDLE cycle.
  - An op accepted at edge 0 runs CALC during cycles 1..N.
  - out_valid=1 from cycle N+1.
  - Accept-to-result is N+1 cycles (MUL at XLEN=64: 65 cycles; DIVW: 33).
- Multiply:
  - Low XLEN bits of the product.
  - Signedness irrelevant for the low half; operands are treated as unsigned.
- Divide:
  - Signed ops divide magnitudes unsigned, then fix signs.
  - Quotient is negative iff operand signs differ (and divisor != 0).
  - Remainder takes the dividend's sign.
- Special cases, RISC-V semantics:
  - Divisor 0: quotient all-ones, remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend, remainder 0.
  - These produce results at normal latency unless MDU_EARLY_OUT_EN.
- W ops:
  - Operands are low 32 bits, sign-extended (MULW, DIVW, REMW) or zero-extended (DIVUW, REMUW).
  - The 32-bit result is always sign-extended to XLEN, including DIVUW and REMUW.
  - At XLEN=32 the W ops behave as their non-W counterparts.
- Flush:
  - Any state → IDLE at the next edge; out_valid=0 next cycle; no result emitted.
  - flush and in_valid together: flush wins and the op is not accepted.
  - flush in DONE together with out_ready: the handshake completes in that cycle, and the unit is IDLE next cycle.
- Inputs are sampled only at accept; in_a, in_b and in_op may change freely afterwards.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: at accept, three cases skip CALC and go straight to DONE (accept-to-out_valid = 1 cycle), with results as above:
  - divisor 0;
  - signed overflow;
  - multiply with either operand 0.
- Not defined: these cases iterate the full N cycles; results are identical.

Test Plan:
- MUL, XLEN=64, a=0xFFFF_FFFF_FFFF_FFFF, b=3 → out_valid at cycle 65, result 0xFFFF_FFFF_FFFF_FFFD, tag echoed.
- DIV a=-7, b=2 → quotient -3 (0xFFFF_FFFF_FFFF_FFFD); REM with the same operands → -1; REMU a=7, b=0 → 7; DIVU a=7, b=0 → 0xFFFF_FFFF_FFFF_FFFF.
- DIVW a=0x8000_0000, b=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000 at cycle 33; DIVUW a=0xFFFF_FFFE, b=1 → 0xFFFF_FFFF_FFFF_FFFE.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → result and tag stable, in_ready=0; out_ready=1 → IDLE next cycle, accepting again the following cycle.
- Flush at CALC cycle 10 of a DIV → out_valid never rises for that op; a new MULW 6×7 issued after flush → result 42, tag of the new op.
- With MDU_EARLY_OUT_EN: DIV by 0 and MUL by 0 → out_valid 1 cycle after accept; without it → cycle 65; results identical in both builds.
